// File: rtl/onewire_master_if.sv
// Command/response and pad bundle for the byte-level 1-Wire initiator.
//
// Handshake: a command transfers on a rising clk_2m4 edge where both
// cmd_valid and cmd_ready are high. cmd_ready is high only while the engine
// is idle, so cmd_valid raised while busy is dropped (never queued).
// rsp_valid is a single-cycle pulse with no back-pressure; rsp_rdata,
// rsp_presence and rsp_err are stable while it is high and hold afterwards.
// Pad: dq_ena=1 pulls DQ low, dq_ena=0 releases it; dq_out is always 0.
interface onewire_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_presence;
  logic       rsp_err;
  logic       busy;
  logic       dq_in;
  logic       dq_out;
  logic       dq_ena;

  // View of the 1-Wire initiator itself.
  modport master (
    input  cmd_valid, cmd_op, cmd_wdata, dq_in,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_presence, rsp_err, busy,
    output dq_out, dq_ena
  );

  // View of the host issuing commands and of the pad/bus side.
  modport slave (
    output cmd_valid, cmd_op, cmd_wdata, dq_in,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_presence, rsp_err, busy,
    input  dq_out, dq_ena
  );
endinterface

// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus initiator running from the 2.4 MHz system clock.
// Generates reset/presence, write-byte and read-byte sequences (LSB first)
// on an open-drain DQ pad. All timing parameters are in clk_2m4 cycles.
module onewire_master #(
  parameter int unsigned T_RSTL = 1152, // reset low time
  parameter int unsigned T_PDS  = 168,  // presence sample point after release
  parameter int unsigned T_RSTH = 1152, // recovery after reset low
  parameter int unsigned T_LOW1 = 14,   // low time for write-1 / read slots
  parameter int unsigned T_LOW0 = 144,  // low time for write-0 slots
  parameter int unsigned T_SAMP = 36,   // read sample point from slot start
  parameter int unsigned T_SLOT = 168   // full slot length
) (
  input  logic                    clk_2m4,
  input  logic                    owpo_rstn,
  onewire_master_if.master        bus,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_LOW   = 3'd1,
    ST_RST_WAIT  = 3'd2,
    ST_SLOT_LOW  = 3'd3,
    ST_SLOT_HIGH = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] OP_RESET   = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Terminal counts: cnt_q equals these on the last cycle of each interval.
  localparam logic [10:0] RSTL_END = 11'(T_RSTL - 1);
  localparam logic [10:0] PDS_END  = 11'(T_PDS - 1);
  localparam logic [10:0] RSTH_END = 11'(T_RSTH - 1);
  localparam logic [10:0] LOW1_END = 11'(T_LOW1 - 1);
  localparam logic [10:0] LOW0_END = 11'(T_LOW0 - 1);
  localparam logic [10:0] SAMP_END = 11'(T_SAMP - 1);
  localparam logic [10:0] SLOT_END = 11'(T_SLOT - 1);

  state_e      state_q;
  logic [10:0] cnt_q;
  logic [2:0]  bitn_q;
  logic [7:0]  sr_q;
  logic [1:0]  op_q;
  logic        presence_q;
  logic        err_q;
  logic        dq_meta_q;
  logic        dq_s_q;
  logic        dq_ena_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_presence_q;
  logic        rsp_err_q;

  logic        accept;
  logic [10:0] low_end_d;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  // A write-0 holds the bus low for the long interval; write-1 and read
  // slots only give the short start pulse.
  assign low_end_d = ((op_q == OP_WRITE) && !sr_q[0]) ? LOW0_END : LOW1_END;

  // Two-flop synchronizer for the asynchronous pad input; idle bus is high.
  always_ff @(posedge clk_2m4) begin
    if (!owpo_rstn) begin
      dq_meta_q <= 1'b1;
      dq_s_q    <= 1'b1;
    end else begin
      dq_meta_q <= bus.dq_in;
      dq_s_q    <= dq_meta_q;
    end
  end

  // Sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clk_2m4) begin
    if (!owpo_rstn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bitn_q         <= '0;
      sr_q           <= '0;
      op_q           <= OP_RESET;
      presence_q     <= 1'b0;
      err_q          <= 1'b0;
      dq_ena_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_presence_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + 11'd1;
      rsp_valid_q <= 1'b0;
      // The pad follows the low-driving states one cycle later.
      dq_ena_q    <= (state_q == ST_RST_LOW) || (state_q == ST_SLOT_LOW);

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= bus.cmd_op;
            sr_q       <= bus.cmd_wdata;
            cnt_q      <= '0;
            bitn_q     <= '0;
            presence_q <= 1'b0;
            err_q      <= (bus.cmd_op == OP_ILLEGAL);
            case (bus.cmd_op)
              OP_RESET:          state_q <= ST_RST_LOW;
              OP_WRITE, OP_READ: state_q <= ST_SLOT_LOW;
              default:           state_q <= ST_DONE;
            endcase
          end
        end

        ST_RST_LOW: begin
          if (cnt_q == RSTL_END) begin
            state_q <= ST_RST_WAIT;
            cnt_q   <= '0;
          end
        end

        ST_RST_WAIT: begin
          if (cnt_q == PDS_END) begin
            presence_q <= ~dq_s_q;
          end
          if (cnt_q == RSTH_END) begin
            // Anything still holding DQ low at the end of recovery is a fault.
            err_q   <= ~dq_s_q;
            state_q <= ST_DONE;
            cnt_q   <= '0;
          end
        end

        ST_SLOT_LOW: begin
          // cnt_q keeps running: sample and slot-end points are measured
          // from the start of the slot, not from the release.
          if (cnt_q == low_end_d) begin
            state_q <= ST_SLOT_HIGH;
          end
        end

        ST_SLOT_HIGH: begin
          if ((op_q == OP_READ) && (cnt_q == SAMP_END)) begin
            sr_q <= {dq_s_q, sr_q[7:1]};
          end
          if (cnt_q == SLOT_END) begin
            if (op_q == OP_WRITE) begin
              sr_q <= {1'b0, sr_q[7:1]};
            end
            cnt_q <= '0;
            if (bitn_q == 3'd7) begin
              state_q <= ST_DONE;
            end else begin
              bitn_q  <= bitn_q + 3'd1;
              state_q <= ST_SLOT_LOW;
            end
          end
        end

        ST_DONE: begin
          rsp_valid_q    <= 1'b1;
          rsp_presence_q <= presence_q;
          rsp_err_q      <= err_q;
          if (op_q == OP_READ) begin
            rsp_rdata_q <= sr_q;
          end
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.dq_out       = 1'b0;
  assign bus.dq_ena       = dq_ena_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_presence = rsp_presence_q;
  assign bus.rsp_err      = rsp_err_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master: a simple 1-Wire slave model on
// the pad, a pad/response monitor and per-scenario test tasks.
`timescale 1ns/1ps
module tb_onewire_master;

  localparam int T_RSTL = 1152;
  localparam int T_RSTH = 1152;
  localparam int T_LOW1 = 14;
  localparam int T_LOW0 = 144;
  localparam int T_SLOT = 168;

  logic       clk_2m4;
  logic       owpo_rstn;
  logic [2:0] state_o;

  onewire_master_if bus();

  onewire_master dut (
    .clk_2m4   (clk_2m4),
    .owpo_rstn (owpo_rstn),
    .bus       (bus),
    .state_o   (state_o)
  );

  // Clock / reset
  initial clk_2m4 = 1'b0;
  always #208 clk_2m4 = ~clk_2m4;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc;
  int rsp_cyc;
  int rsp_cnt = 0;

  logic [9:0] exp_q[$];       // {rsp_rdata, rsp_presence, rsp_err}
  int         pulse_exp_q[$]; // expected dq_ena low-pulse lengths
  int         pulse_obs_q[$]; // observed dq_ena low-pulse lengths
  int         rise_q[$];      // cycle stamps of dq_ena rising

  logic       slave_low;
  logic       stuck_low;
  logic       pres_en;
  logic       rd_en;
  logic [7:0] rd_byte;
  logic [2:0] rd_bit;
  logic [7:0] model_rdata;

  // Open-drain bus: low if the master or the slave pulls it.
  assign bus.dq_in = ~(bus.dq_ena | slave_low | stuck_low);

  initial begin : cycle_count
    forever begin
      @(posedge clk_2m4);
      cyc++;
    end
  end

  // Slave model: presence pulse after a long reset low, and read-slot data.
  initial begin : slave_model
    int low_len;
    slave_low = 1'b0;
    forever begin
      @(posedge bus.dq_ena);
      if (rd_en) begin
        if (!rd_byte[rd_bit]) begin
          slave_low = 1'b1;
          repeat (72) @(posedge clk_2m4);
          slave_low = 1'b0;
        end
        rd_bit++;
      end else begin
        low_len = 0;
        while (bus.dq_ena === 1'b1) begin
          @(posedge clk_2m4);
          low_len++;
        end
        if (pres_en && low_len > 400) begin
          repeat (72) @(posedge clk_2m4);
          slave_low = 1'b1;
          repeat (288) @(posedge clk_2m4);
          slave_low = 1'b0;
        end
      end
    end
  end

  // Pad / response monitor, sampled on the falling edge.
  initial begin : monitor
    int   hi_len;
    logic ena_prev;
    hi_len   = 0;
    ena_prev = 1'b0;
    forever begin
      @(negedge clk_2m4);
      if (bus.dq_ena === 1'b1) begin
        if (!ena_prev) rise_q.push_back(cyc);
        hi_len++;
      end else if (hi_len != 0) begin
        pulse_obs_q.push_back(hi_len);
        hi_len = 0;
      end
      ena_prev = (bus.dq_ena === 1'b1);
      if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end
  end

  // Driver tasks
  task automatic clear_obs();
    pulse_obs_q.delete();
    pulse_exp_q.delete();
    rise_q.delete();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] wd, input bit at_once);
    if (!at_once) @(negedge clk_2m4);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wdata = wd;
    @(posedge clk_2m4);
    @(negedge clk_2m4);
    bus.cmd_valid = 1'b0;
    accept_cyc    = cyc;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got     = 1'b1;
        rsp_cyc = cyc;
      end else begin
        @(negedge clk_2m4);
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    owpo_rstn     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_wdata = 8'h00;
    stuck_low     = 1'b0;
    pres_en       = 1'b0;
    rd_en         = 1'b0;
    rd_byte       = 8'h00;
    rd_bit        = 3'd0;
    model_rdata   = 8'h00;
    repeat (4) @(negedge clk_2m4);
    n_vec++;
    if ({bus.dq_ena, bus.dq_out, bus.cmd_ready, bus.rsp_valid, bus.busy} !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_ctl: {ena,out,ready,rvalid,busy}=%b expected 00100",
               {bus.dq_ena, bus.dq_out, bus.cmd_ready, bus.rsp_valid, bus.busy});
    end
    n_vec++;
    if ({bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== 10'h000) begin
      n_err++;
      $display("FAIL reset_rsp: {rdata,pres,err}=%h expected 000",
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err});
    end
    n_vec++;
    if (state_o !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d expected 0", state_o);
    end
    owpo_rstn = 1'b1;
    repeat (2) @(negedge clk_2m4);
  endtask

  task automatic test_reset_op(input bit pres, input bit stuck, input bit exp_pres, input bit exp_err);
    bit         got;
    logic [9:0] exp;
    clear_obs();
    pres_en   = pres;
    stuck_low = stuck;
    exp_q.push_back({model_rdata, exp_pres, exp_err});
    send_cmd(2'b00, 8'h00, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_accept: busy=%b ready=%b expected busy=1 ready=0", bus.busy, bus.cmd_ready);
    end
    wait_rsp(T_RSTL + T_RSTH + 50, got);
    stuck_low = 1'b0;
    pres_en   = 1'b0;
    exp = exp_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL rst_rsp: no rsp_valid within budget, expected %h", exp);
    end else if ({bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== exp) begin
      n_err++;
      $display("FAIL rst_rsp: {rdata,pres,err}=%h expected %h",
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err}, exp);
    end
    // Latency counted from the accepting edge.
    n_vec++;
    if (!got || (rsp_cyc - accept_cyc) != T_RSTL + T_RSTH + 1) begin
      n_err++;
      $display("FAIL rst_latency: got=%0d cycles=%0d expected %0d", got,
               rsp_cyc - accept_cyc, T_RSTL + T_RSTH + 1);
    end
    n_vec++;
    if (pulse_obs_q.size() != 1 || rise_q.size() != 1) begin
      n_err++;
      $display("FAIL rst_pulse_count: pulses=%0d rises=%0d expected 1", pulse_obs_q.size(), rise_q.size());
    end else if (pulse_obs_q[0] != T_RSTL || (rise_q[0] - accept_cyc) != 1) begin
      n_err++;
      $display("FAIL rst_pulse: len=%0d delay=%0d expected len=%0d delay=1",
               pulse_obs_q[0], rise_q[0] - accept_cyc, T_RSTL);
    end
  endtask

  task automatic test_byte_op(input logic [1:0] op, input logic [7:0] wd,
                              input logic [7:0] slave_byte, input bit at_once);
    bit         got;
    bit         period_ok;
    logic [9:0] exp;
    int         e;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      pulse_exp_q.push_back((op == 2'b01 && !wd[i]) ? T_LOW0 : T_LOW1);
    end
    if (op == 2'b10) begin
      rd_en       = 1'b1;
      rd_byte     = slave_byte;
      rd_bit      = 3'd0;
      model_rdata = slave_byte;
    end
    exp_q.push_back({model_rdata, 2'b00});
    send_cmd(op, wd, at_once);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL byte_accept: busy=%b expected 1 (op=%b)", bus.busy, op);
    end
    wait_rsp(8 * T_SLOT + 50, got);
    rd_en = 1'b0;
    exp = exp_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL byte_rsp: no rsp_valid within budget (op=%b), expected %h", op, exp);
    end else if ({bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== exp) begin
      n_err++;
      $display("FAIL byte_rsp: op=%b {rdata,pres,err}=%h expected %h", op,
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err}, exp);
    end
    n_vec++;
    if (rise_q.size() != 8) begin
      n_err++;
      $display("FAIL byte_slots: slot count=%0d expected 8 (op=%b)", rise_q.size(), op);
    end else begin
      period_ok = 1'b1;
      for (int i = 1; i < 8; i++) if (rise_q[i] - rise_q[i-1] != T_SLOT) period_ok = 1'b0;
      // Completion measured from the first slot's falling DQ edge.
      if (!period_ok || !got || (rsp_cyc - rise_q[0]) != 8 * T_SLOT || (rise_q[0] - accept_cyc) != 1) begin
        n_err++;
        $display("FAIL byte_timing: period_ok=%b first_delay=%0d done=%0d expected 1 and %0d",
                 period_ok, rise_q[0] - accept_cyc, rsp_cyc - rise_q[0], 8 * T_SLOT);
      end
    end
    for (int i = 0; i < 8; i++) begin
      e = pulse_exp_q.pop_front();
      n_vec++;
      if (i >= pulse_obs_q.size()) begin
        n_err++;
        $display("FAIL byte_pulse[%0d]: missing, expected %0d", i, e);
      end else if (pulse_obs_q[i] != e) begin
        n_err++;
        $display("FAIL byte_pulse[%0d]: len=%0d expected %0d (op=%b wd=%h)", i, pulse_obs_q[i], e, op, wd);
      end
    end
  endtask

  task automatic test_ds18b20();
    logic [7:0] rnd;
    test_reset_op(1'b1, 1'b0, 1'b1, 1'b0);
    test_byte_op(2'b01, 8'hCC, 8'h00, 1'b0);
    test_byte_op(2'b01, 8'hBE, 8'h00, 1'b0);
    test_byte_op(2'b10, 8'hFF, 8'h50, 1'b0);
    // Back-to-back: next command presented during the rsp_valid cycle.
    rnd = 8'($urandom_range(0, 255));
    test_byte_op(2'b10, 8'($urandom_range(0, 255)), rnd, 1'b1);
    test_byte_op(2'b01, 8'($urandom_range(0, 255)), 8'h00, 1'b1);
  endtask

  task automatic test_illegal();
    bit         got;
    logic [9:0] exp;
    clear_obs();
    exp_q.push_back({model_rdata, 2'b01});
    send_cmd(2'b11, 8'($urandom_range(0, 255)), 1'b0);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ill_accept: busy=%b expected 1", bus.busy);
    end
    wait_rsp(5, got);
    exp = exp_q.pop_front();
    n_vec++;
    if (!got || (rsp_cyc - accept_cyc) != 1) begin
      n_err++;
      $display("FAIL ill_latency: got=%b cycles=%0d expected 1", got, rsp_cyc - accept_cyc);
    end
    n_vec++;
    if ({bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== exp) begin
      n_err++;
      $display("FAIL ill_rsp: {rdata,pres,err}=%h expected %h",
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err}, exp);
    end
    @(negedge clk_2m4);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ill_pulse_width: rsp_valid=%b expected 0 one cycle later", bus.rsp_valid);
    end
    repeat (10) @(negedge clk_2m4);
    n_vec++;
    if (rise_q.size() != 0) begin
      n_err++;
      $display("FAIL ill_bus: dq_ena rises=%0d expected 0", rise_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    bit         got;
    logic [9:0] exp;
    logic [7:0] wd;
    int         c0;
    int         e;
    clear_obs();
    wd = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) pulse_exp_q.push_back(wd[i] ? T_LOW1 : T_LOW0);
    exp_q.push_back({model_rdata, 2'b00});
    c0 = rsp_cnt;
    send_cmd(2'b01, wd, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 8 * T_SLOT + 50 && !got; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got     = 1'b1;
        rsp_cyc = cyc;
      end else begin
        bus.cmd_valid = (i == 100 || i == 500 || i == 1000);
        bus.cmd_op    = (i == 500) ? 2'b11 : 2'b00;
        bus.cmd_wdata = 8'hFF;
        @(negedge clk_2m4);
      end
    end
    bus.cmd_valid = 1'b0;
    exp = exp_q.pop_front();
    n_vec++;
    if (!got || {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== exp) begin
      n_err++;
      $display("FAIL busy_rsp: got=%b {rdata,pres,err}=%h expected %h", got,
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err}, exp);
    end
    for (int i = 0; i < 8; i++) begin
      e = pulse_exp_q.pop_front();
      n_vec++;
      if (i >= pulse_obs_q.size() || pulse_obs_q[i] != e) begin
        n_err++;
        $display("FAIL busy_pulse[%0d]: len=%0d expected %0d (wd=%h)", i,
                 (i < pulse_obs_q.size()) ? pulse_obs_q[i] : -1, e, wd);
      end
    end
    repeat (40) @(negedge clk_2m4);
    n_vec++;
    if ((rsp_cnt - c0) != 1 || rise_q.size() != 8 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore: responses=%0d slots=%0d busy=%b expected 1, 8, 0",
               rsp_cnt - c0, rise_q.size(), bus.busy);
    end
  endtask

  task automatic test_reset_midop();
    int c0;
    clear_obs();
    pres_en = 1'b1;
    c0 = rsp_cnt;
    send_cmd(2'b00, 8'h00, 1'b0);
    repeat (300) @(negedge clk_2m4);
    n_vec++;
    if (bus.dq_ena !== 1'b1) begin
      n_err++;
      $display("FAIL midop_low: dq_ena=%b expected 1 during reset low", bus.dq_ena);
    end
    owpo_rstn = 1'b0;
    @(negedge clk_2m4);
    n_vec++;
    if ({bus.dq_ena, bus.cmd_ready, bus.busy, bus.rsp_valid, state_o} !== {4'b0100, 3'd0}) begin
      n_err++;
      $display("FAIL midop_reset: {ena,ready,busy,rvalid,state}=%b expected 0100000",
               {bus.dq_ena, bus.cmd_ready, bus.busy, bus.rsp_valid, state_o});
    end
    n_vec++;
    if ({bus.rsp_rdata, bus.rsp_presence, bus.rsp_err} !== 10'h000) begin
      n_err++;
      $display("FAIL midop_rsp_clear: {rdata,pres,err}=%h expected 000",
               {bus.rsp_rdata, bus.rsp_presence, bus.rsp_err});
    end
    owpo_rstn   = 1'b1;
    model_rdata = 8'h00;
    repeat (T_RSTL + T_RSTH + 50) @(negedge clk_2m4);
    pres_en = 1'b0;
    n_vec++;
    if ((rsp_cnt - c0) != 0 || rise_q.size() != 1) begin
      n_err++;
      $display("FAIL midop_silent: responses=%0d rises=%0d expected 0 and 1", rsp_cnt - c0, rise_q.size());
    end
    test_reset_op(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Sequence and final report
  initial begin : main
    test_reset();
    test_reset_op(1'b1, 1'b0, 1'b1, 1'b0);
    test_reset_op(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset_op(1'b0, 1'b1, 1'b1, 1'b1);
    test_byte_op(2'b01, 8'hCC, 8'h00, 1'b0);
    test_ds18b20();
    test_illegal();
    test_busy_ignore();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
